// File: rtl/stream_len_extractor_pkg.sv
// Shared types for the stream length extractor: packet FSM states and
// the bit position of the saturation flag inside a length record {sat, len}.
package stream_len_extractor_pkg;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_IN_PKT = 1'b1
  } pkt_state_e;

  function automatic int unsigned rec_sat_bit(input int unsigned len_width);
    return len_width;
  endfunction

endpackage

// File: rtl/stream_len_extractor_len_fifo.sv
// Length-record queue: synchronous FIFO with registered full/empty flags.
// A pop while full frees the slot only after the clock edge.
module len_fifo
  import stream_len_extractor_pkg::*;
#(
  parameter int unsigned W     = 33,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         srst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   occ_r;
  logic [AW:0]   occ_nxt_s;
  logic          full_r;
  logic          empty_r;
  logic          do_push_s;
  logic          do_pop_s;

  assign do_push_s = push & ~full_r;
  assign do_pop_s  = pop & ~empty_r;
  assign head      = mem_r[rd_ptr_r];
  assign full      = full_r;
  assign empty     = empty_r;

  // Next occupancy; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    occ_nxt_s = occ_r;
    if (do_push_s && !do_pop_s) begin
      occ_nxt_s = occ_r + (AW+1)'(1);
    end else if (do_pop_s && !do_push_s) begin
      occ_nxt_s = occ_r - (AW+1)'(1);
    end else begin
      occ_nxt_s = occ_r;
    end
  end

  // Pointer, occupancy and flag registers.
  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      occ_r    <= {(AW+1){1'b0}};
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      occ_r   <= occ_nxt_s;
      full_r  <= (occ_nxt_s == (AW+1)'(DEPTH));
      empty_r <= (occ_nxt_s == {(AW+1){1'b0}});
    end
  end

  // Record storage; contents are only meaningful behind the valid pointers.
  always_ff @(posedge clk) begin
    if (do_push_s) mem_r[wr_ptr_r] <= push_data;
  end

endmodule

// File: rtl/stream_len_extractor.sv
// Zero-latency AXI4-Stream pass-through that counts beats per TLAST-framed
// packet and queues one {sat, len} record per packet on a valid/ready port.
module stream_len_extractor
  import stream_len_extractor_pkg::*;
#(
  parameter int unsigned C_S_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned C_M_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned C_LEN_WIDTH          = 32,
  parameter int unsigned C_LEN_FIFO_DEPTH     = 4
) (
  input  logic                                S_AXIS_ACLK,
  input  logic                                S_AXIS_ARESET,
  input  logic                                S_AXIS_TVALID,
  output logic                                S_AXIS_TREADY,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0]     S_AXIS_TDATA,
  input  logic [(C_S_AXIS_TDATA_WIDTH/8)-1:0] S_AXIS_TSTRB,
  input  logic                                S_AXIS_TLAST,
  output logic                                M_AXIS_TVALID,
  input  logic                                M_AXIS_TREADY,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]     M_AXIS_TDATA,
  output logic [(C_M_AXIS_TDATA_WIDTH/8)-1:0] M_AXIS_TSTRB,
  output logic                                M_AXIS_TLAST,
  output logic [C_LEN_WIDTH-1:0]              stream_len,
  output logic                                len_sat,
  output logic                                len_valid,
  input  logic                                len_ready,
  output logic                                in_packet
);

  localparam int unsigned REC_W   = C_LEN_WIDTH + 1;
  localparam int unsigned SAT_BIT = rec_sat_bit(C_LEN_WIDTH);

  pkt_state_e             state_r;
  logic [C_LEN_WIDTH-1:0] cnt_r;
  logic                   sat_r;
  logic [C_LEN_WIDTH-1:0] cnt_inc_s;
  logic                   cnt_at_max_s;
  logic                   accept_en_s;
  logic                   xfer_s;
  logic                   q_full_s;
  logic                   q_empty_s;
  logic                   push_s;
  logic                   pop_s;
  logic [REC_W-1:0]       push_rec_s;
  logic [REC_W-1:0]       head_rec_s;

  // A full record queue back-pressures the whole stream, so no TLAST is ever lost.
  assign accept_en_s   = ~S_AXIS_ARESET & ~q_full_s;
  assign S_AXIS_TREADY = M_AXIS_TREADY & accept_en_s;
  assign M_AXIS_TVALID = S_AXIS_TVALID & accept_en_s;
  assign M_AXIS_TDATA  = S_AXIS_TDATA;
  assign M_AXIS_TSTRB  = S_AXIS_TSTRB;
  assign M_AXIS_TLAST  = S_AXIS_TLAST;
  assign xfer_s        = S_AXIS_TVALID & S_AXIS_TREADY;

  assign cnt_at_max_s = (cnt_r == {C_LEN_WIDTH{1'b1}});
  assign cnt_inc_s    = cnt_at_max_s ? cnt_r : (cnt_r + C_LEN_WIDTH'(1));
  assign push_s       = xfer_s & S_AXIS_TLAST;
  assign push_rec_s   = {sat_r | cnt_at_max_s, cnt_inc_s};
  assign pop_s        = ~q_empty_s & len_ready;

  assign stream_len = head_rec_s[C_LEN_WIDTH-1:0];
  assign len_sat    = head_rec_s[SAT_BIT];
  assign len_valid  = ~q_empty_s;
  assign in_packet  = (state_r == ST_IN_PKT);

  // Packet framing FSM with the saturating beat counter.
  always_ff @(posedge S_AXIS_ACLK) begin
    if (S_AXIS_ARESET) begin
      state_r <= ST_IDLE;
      cnt_r   <= {C_LEN_WIDTH{1'b0}};
      sat_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE:   if (xfer_s && !S_AXIS_TLAST) state_r <= ST_IN_PKT;
        ST_IN_PKT: if (xfer_s && S_AXIS_TLAST)  state_r <= ST_IDLE;
        default:   state_r <= ST_IDLE;
      endcase
      if (xfer_s) begin
        if (S_AXIS_TLAST) begin
          cnt_r <= {C_LEN_WIDTH{1'b0}};
          sat_r <= 1'b0;
        end else begin
          cnt_r <= cnt_inc_s;
          sat_r <= sat_r | cnt_at_max_s;
        end
      end
    end
  end

  len_fifo #(
    .W     (REC_W),
    .DEPTH (C_LEN_FIFO_DEPTH)
  ) u_len_fifo (
    .clk       (S_AXIS_ACLK),
    .srst      (S_AXIS_ARESET),
    .push      (push_s),
    .push_data (push_rec_s),
    .pop       (pop_s),
    .head      (head_rec_s),
    .full      (q_full_s),
    .empty     (q_empty_s)
  );

endmodule

// File: tb/tb_stream_len_extractor.sv
// Randomised bench: two extractors (32-bit and 3-bit counters) share one stream;
// a queue-based model of packets and records predicts every handshake and record.
module tb_stream_len_extractor;

  localparam int DEPTH = 4;
  localparam int NARROW_MAX = 7;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_tvalid = 1'b0;
  logic [31:0] s_tdata = 32'd0;
  logic [3:0]  s_tstrb = 4'd0;
  logic        s_tlast = 1'b0;
  logic        m_tready = 1'b1;
  logic        len_ready = 1'b1;
  int          m_mode = 0;
  int          lr_mode = 0;

  logic        a_s_tready, a_m_tvalid, a_m_tlast, a_len_sat, a_len_valid, a_in_packet;
  logic [31:0] a_m_tdata, a_stream_len;
  logic [3:0]  a_m_tstrb;
  logic        b_s_tready, b_m_tvalid, b_m_tlast, b_len_sat, b_len_valid, b_in_packet;
  logic [31:0] b_m_tdata;
  logic [2:0]  b_stream_len;
  logic [3:0]  b_m_tstrb;

  typedef struct packed {logic [31:0] d; logic [3:0] s; logic l;} beat_t;
  beat_t       exp_beats[$];
  int unsigned rec_q[$];
  int unsigned pkt_beats = 0;
  int          checks = 0;
  int          errors = 0;

  stream_len_extractor dut_a (
    .S_AXIS_ACLK(clk), .S_AXIS_ARESET(rst), .S_AXIS_TVALID(s_tvalid), .S_AXIS_TREADY(a_s_tready),
    .S_AXIS_TDATA(s_tdata), .S_AXIS_TSTRB(s_tstrb), .S_AXIS_TLAST(s_tlast),
    .M_AXIS_TVALID(a_m_tvalid), .M_AXIS_TREADY(m_tready), .M_AXIS_TDATA(a_m_tdata),
    .M_AXIS_TSTRB(a_m_tstrb), .M_AXIS_TLAST(a_m_tlast), .stream_len(a_stream_len),
    .len_sat(a_len_sat), .len_valid(a_len_valid), .len_ready(len_ready), .in_packet(a_in_packet));

  stream_len_extractor #(.C_LEN_WIDTH(3)) dut_b (
    .S_AXIS_ACLK(clk), .S_AXIS_ARESET(rst), .S_AXIS_TVALID(s_tvalid), .S_AXIS_TREADY(b_s_tready),
    .S_AXIS_TDATA(s_tdata), .S_AXIS_TSTRB(s_tstrb), .S_AXIS_TLAST(s_tlast),
    .M_AXIS_TVALID(b_m_tvalid), .M_AXIS_TREADY(m_tready), .M_AXIS_TDATA(b_m_tdata),
    .M_AXIS_TSTRB(b_m_tstrb), .M_AXIS_TLAST(b_m_tlast), .stream_len(b_stream_len),
    .len_sat(b_len_sat), .len_valid(b_len_valid), .len_ready(len_ready), .in_packet(b_in_packet));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Ready generators for the output stream and the record port.
  always @(posedge clk) begin
    #1;
    case (m_mode)
      0: m_tready = 1'b1;
      1: m_tready = ~m_tready;
      default: m_tready = ($urandom_range(0, 3) != 0);
    endcase
    case (lr_mode)
      0: len_ready = 1'b1;
      1: len_ready = ($urandom_range(0, 1) == 1);
      default: len_ready = 1'b0;
    endcase
  end

  // Reference model: checks outputs, then advances on the handshakes of the coming edge.
  always @(negedge clk) begin
    logic exp_acc, xfer, pop;
    int unsigned n;
    beat_t eb;
    exp_acc = !rst && (rec_q.size() < DEPTH);
    xfer = s_tvalid && m_tready && exp_acc;
    pop = len_ready && (rec_q.size() != 0);
    check("a_s_tready", a_s_tready, m_tready & exp_acc);
    check("b_s_tready", b_s_tready, m_tready & exp_acc);
    check("a_m_tvalid", a_m_tvalid, s_tvalid & exp_acc);
    check("b_m_tvalid", b_m_tvalid, s_tvalid & exp_acc);
    check("a_len_valid", a_len_valid, rec_q.size() != 0);
    check("b_len_valid", b_len_valid, rec_q.size() != 0);
    check("a_in_packet", a_in_packet, pkt_beats != 0);
    check("b_in_packet", b_in_packet, pkt_beats != 0);
    if (rec_q.size() != 0) begin
      n = rec_q[0];
      check("a_stream_len", a_stream_len, n);
      check("a_len_sat", a_len_sat, 1'b0);
      check("b_stream_len", b_stream_len, (n > NARROW_MAX) ? NARROW_MAX : n);
      check("b_len_sat", b_len_sat, n > NARROW_MAX);
    end
    if (xfer) begin
      if (exp_beats.size() == 0) begin
        check("unexpected_beat", 1'b1, 1'b0);
      end else begin
        eb = exp_beats.pop_front();
        check("a_m_tdata", {a_m_tdata, a_m_tstrb, a_m_tlast}, eb);
        check("b_m_tdata", {b_m_tdata, b_m_tstrb, b_m_tlast}, eb);
      end
    end
    if (rst) begin
      rec_q.delete();
      pkt_beats = 0;
    end else begin
      if (pop) void'(rec_q.pop_front());
      if (xfer) begin
        if (s_tlast) begin
          rec_q.push_back(pkt_beats + 1);
          pkt_beats = 0;
        end else begin
          pkt_beats++;
        end
      end
    end
  end

  task automatic wait_accept();
    int w;
    w = 0;
    forever begin
      @(negedge clk);
      if (a_s_tready) break;
      w++;
      if (w >= 500) begin
        check("accept_timeout", 1'b1, 1'b0);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic send_pkt(input int n, input int max_gap, input bit do_last);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, max_gap)) begin @(posedge clk); #1; end
      b.d = $urandom;
      b.s = 4'($urandom);
      b.l = do_last && (i == n - 1);
      s_tdata = b.d; s_tstrb = b.s; s_tlast = b.l; s_tvalid = 1'b1;
      exp_beats.push_back(b);
      wait_accept();
      s_tvalid = 1'b0;
      s_tlast = 1'b0;
    end
  endtask

  task automatic drain();
    lr_mode = 0;
    for (int w = 0; w < 300 && rec_q.size() != 0; w++) @(posedge clk);
    @(posedge clk); #1;
    check("drained", a_len_valid, 1'b0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_len_valid", a_len_valid, 1'b0);
    check("reset_in_packet", a_in_packet, 1'b0);
    // records 5, 1, 8 with everything ready
    send_pkt(5, 0, 1'b1); send_pkt(1, 0, 1'b1); send_pkt(8, 0, 1'b1);
    drain();
    // fill the queue, stall the 5th packet, release it with one pop
    lr_mode = 2;
    repeat (4) send_pkt(1, 0, 1'b1);
    fork
      send_pkt(1, 0, 1'b1);
      begin
        repeat (6) @(posedge clk);
        lr_mode = 0;
        @(posedge clk);
        lr_mode = 2;
      end
    join
    drain();
    // toggling output ready
    m_mode = 1;
    send_pkt(6, 0, 1'b1);
    m_mode = 0;
    drain();
    // narrow counter saturates on the 10-beat packet, not on the 2-beat one
    send_pkt(10, 0, 1'b1); send_pkt(2, 0, 1'b1);
    drain();
    // reset mid-packet discards the partial count
    send_pkt(3, 0, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    send_pkt(4, 0, 1'b1);
    drain();
    // push and pop in the same cycle with two records queued
    lr_mode = 2;
    send_pkt(2, 0, 1'b1); send_pkt(3, 0, 1'b1);
    lr_mode = 0;
    send_pkt(1, 0, 1'b1); send_pkt(2, 0, 1'b1);
    drain();
    // random traffic
    for (int p = 0; p < 40; p++) begin
      m_mode = $urandom_range(0, 2);
      lr_mode = $urandom_range(0, 1);
      send_pkt($urandom_range(1, 12), 2, 1'b1);
    end
    m_mode = 0;
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
